cwru_frame_rx: RTL and testbench
================================

# cwru_frame_rx

Parametrised on-off-keyed frame receiver for the CWRU transceiver RX board. It samples the demodulated serial line (GPIO_1[17] at top level) at mid-bit with a 3-sample majority vote, assembles fixed-length MSB-first frames, checks an inter-frame idle gap and decodes the key code to a seven-segment digit on HEX0. It is the configurable successor of the fixed 8-bit, 4-key receiver: frame length, bit period and gap length are parameters, and it adds framing/code error reporting, a valid strobe and false-start rejection.

## Interface
- CLKS_PER_BIT, 6250, CLK cycles per bit (125 µs at 50 MHz); must be ≥ 4
- FRAME_BITS, 8, bits per frame including the leading start '1'; even, 2..20
- GAP_BITS, 1, idle-low bits required after each frame; ≥ 1

- CLK  in  1  system clock, 50 MHz
- RST  in  1  asynchronous, active-high reset
- RX_IN  in  1  serial line, idle low, asynchronous to CLK
- DATA  out  FRAME_BITS  last good frame, first received bit in MSB
- VALID  out  1  one-cycle pulse when DATA updates
- CODE  out  4  last decoded key index
- CODE_ERR  out  1  one-cycle pulse: frame good, pattern not a legal code
- FRAME_ERR  out  1  one-cycle pulse: gap bit sampled high
- BUSY  out  1  high in every state except IDLE
- HEX0  out  7  active-low gfedcba digit of CODE

## Operation
- RX_IN passes through a 2-FF synchroniser; all logic uses the synchronised signal rx_s.
- Bit counter cnt (0..CLKS_PER_BIT-1); mid = CLKS_PER_BIT/2 (integer). Bit value = majority of rx_s at cnt = mid-1, mid, mid+1.
- States: IDLE, START, DATA, GAP, RECOVER.
- IDLE: rx_s = 1 → START with cnt = 0.
- START: majority at mid = 0 → IDLE (false start, no pulse); = 1 → shift '1' into the frame register, continue counting, enter DATA at cnt wrap.
- DATA: one bit per CLKS_PER_BIT, voted at mid, shifted in LSB-side (first bit ends in MSB). After FRAME_BITS-1 data bits → GAP.
- GAP: GAP_BITS bits voted. Any high → FRAME_ERR pulse, frame discarded, → RECOVER. All low → commit frame → IDLE.
- RECOVER: leave for IDLE only after rx_s has been low for CLKS_PER_BIT consecutive cycles; any high restarts that count.
- Commit: DATA ← frame, VALID pulse. Decode: count n consecutive "10" pairs from the MSB; all remaining bits must be 0; n in 1..FRAME_BITS/2 → CODE ← n-1 and HEX0 updated; otherwise CODE_ERR pulse, with CODE and HEX0 held.
- HEX0 encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset values: DATA = 0, CODE = 0, VALID = CODE_ERR = FRAME_ERR = 0, BUSY = 0, HEX0 = 0111111 ('-'), state IDLE, synchroniser = 0.

## Timing
- Rising RX_IN to IDLE→START: 2–3 CLK (synchroniser and register).
- VALID, CODE_ERR and FRAME_ERR are registered: they rise 1 CLK after the final deciding vote sample (mid+1 of the last gap bit, or of the failing gap bit) and last exactly 1 CLK. DATA, CODE and HEX0 change on the same edge as VALID.
- A new start is accepted the cycle after returning to IDLE; back-to-back frames separated by exactly GAP_BITS low bits must all decode.
- RST asserted mid-frame: all outputs and state clear at once with no pulse; reception resumes at the next rising edge of rx_s after RST falls.
- A single-cycle glitch at any vote sample is out-voted.

## Test plan
- CLKS_PER_BIT=16, FRAME_BITS=8: send 10000000, 10100000, 10101000, 10101010, each followed by 2 low bits -> VALID ×4, DATA 0x80/0xA0/0xA8/0xAA, CODE 0..3, HEX0 1000000, 1111001, 0100100, 0110000.
- High pulse of 4 CLK on idle line -> START aborts, no pulse, BUSY falls back low, HEX0 unchanged.
- Frame 11000000 + gap -> VALID with DATA 0xC0, CODE_ERR pulse, CODE and HEX0 hold the previous value.
- Frame 10100000 with gap bit high -> FRAME_ERR pulse, no VALID, DATA unchanged; RECOVER until 16 low cycles, then 10000000 decodes to CODE 0.
- RST pulse during bit 4 of 10101010 -> outputs reset immediately (HEX0 0111111); the following 10100000 decodes to CODE 1.
- 1-CLK low glitch at the mid sample of a '1' bit in 10101010 -> DATA 0xAA, CODE 3.

Source files
------------

// File: rtl/cwru_frame_rx.sv
// On-off-keyed frame receiver: mid-bit majority sampling, fixed-length MSB-first
// frames, idle-gap check, key-code decode and seven-segment display.
module cwru_frame_rx #(
  parameter int CLKS_PER_BIT = 6250,
  parameter int FRAME_BITS   = 8,
  parameter int GAP_BITS     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  output logic [FRAME_BITS-1:0] DATA,
  output logic                  VALID,
  output logic [3:0]            CODE,
  output logic                  CODE_ERR,
  output logic                  FRAME_ERR,
  output logic                  BUSY,
  output logic [6:0]            HEX0
);

  localparam int MID   = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(GAP_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_GAP,
    ST_RECOVER
  } state_t;

  state_t                state_q, state_d;
  logic                  sync_q, sync_d;
  logic                  rx_s_q, rx_s_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]      gap_idx_q, gap_idx_d;
  logic                  v0_q, v0_d;
  logic                  v1_q, v1_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [3:0]            code_q, code_d;
  logic                  code_err_q, code_err_d;
  logic                  frame_err_q, frame_err_d;
  logic [6:0]            hex_q, hex_d;

  logic                  cnt_wrap;
  logic                  vote_now;
  logic                  maj;
  logic [4:0]            decoded;

  // Returns {legal, n-1} where n counts leading "10" pairs and the rest must be zero.
  function automatic logic [4:0] decode_frame(input logic [FRAME_BITS-1:0] f);
    logic [FRAME_BITS-1:0] t;
    logic [3:0]            n;
    logic                  stop;
    logic                  legal;
    t     = f;
    n     = 4'd0;
    stop  = 1'b0;
    legal = 1'b1;
    for (int i = 0; i < FRAME_BITS / 2; i++) begin
      if (!stop && t[FRAME_BITS-1 -: 2] == 2'b10) begin
        n = n + 4'd1;
      end else begin
        stop = 1'b1;
        if (t[FRAME_BITS-1 -: 2] != 2'b00) legal = 1'b0;
      end
      t = t << 2;
    end
    if (n == 4'd0) legal = 1'b0;
    return {legal, n - 4'd1};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign cnt_wrap = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign vote_now = (cnt_q == CNT_W'(MID + 1));
  assign maj      = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
  assign decoded  = decode_frame(frame_q);

  always_comb begin
    state_d     = state_q;
    sync_d      = RX_IN;
    rx_s_d      = sync_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    gap_idx_d   = gap_idx_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    frame_d     = frame_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    code_d      = code_q;
    code_err_d  = 1'b0;
    frame_err_d = 1'b0;
    hex_d       = hex_q;

    // Bit timing and vote samples are shared by every in-frame state.
    if (state_q == ST_START || state_q == ST_DATA || state_q == ST_GAP) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(MID - 1)) v0_d = rx_s_q;
      if (cnt_q == CNT_W'(MID))     v1_d = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
        if (vote_now) begin
          if (maj) frame_d = {frame_q[FRAME_BITS-2:0], 1'b1};
          else     state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (vote_now) frame_d = {frame_q[FRAME_BITS-2:0], maj};
        if (cnt_wrap) begin
          if (bit_idx_q == 5'(FRAME_BITS - 2)) begin
            state_d   = ST_GAP;
            gap_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end
      end
      ST_GAP: begin
        if (cnt_wrap) gap_idx_d = gap_idx_q + GAP_W'(1);
        if (vote_now) begin
          if (maj) begin
            frame_err_d = 1'b1;
            state_d     = ST_RECOVER;
            cnt_d       = '0;
          end else if (gap_idx_q == GAP_W'(GAP_BITS - 1)) begin
            state_d = ST_IDLE;
            data_d  = frame_q;
            valid_d = 1'b1;
            if (decoded[4]) begin
              code_d = decoded[3:0];
              hex_d  = seg_encode(decoded[3:0]);
            end else begin
              code_err_d = 1'b1;
            end
          end
        end
      end
      ST_RECOVER: begin
        // Wait for one full bit period of continuous low before rearming.
        if (rx_s_q)        cnt_d   = '0;
        else if (cnt_wrap) state_d = ST_IDLE;
        else               cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      sync_q      <= 1'b0;
      rx_s_q      <= 1'b0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      gap_idx_q   <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      frame_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      code_q      <= 4'd0;
      code_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      hex_q       <= 7'b0111111;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_s_q      <= rx_s_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      gap_idx_q   <= gap_idx_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      frame_q     <= frame_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      code_err_q  <= code_err_d;
      frame_err_q <= frame_err_d;
      hex_q       <= hex_d;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign CODE      = code_q;
  assign CODE_ERR  = code_err_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign HEX0      = hex_q;

endmodule

// File: tb/tb_cwru_frame_rx.sv
// Scoreboard bench for cwru_frame_rx: directed frames push expected events,
// a negedge monitor pops and compares whenever the receiver pulses an output.
module tb_cwru_frame_rx;

  localparam int CPB = 16;
  localparam int FB  = 8;
  localparam int GB  = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b0;
  logic [FB-1:0] DATA;
  logic          VALID;
  logic [3:0]    CODE;
  logic          CODE_ERR;
  logic          FRAME_ERR;
  logic          BUSY;
  logic [6:0]    HEX0;

  typedef struct packed {
    logic       frame_err;
    logic       code_err;
    logic [7:0] data;
    logic [3:0] code;
    logic [6:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run  = 0;
  int   fail_count = 0;

  cwru_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BITS  (FB),
    .GAP_BITS    (GB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .DATA     (DATA),
    .VALID    (VALID),
    .CODE     (CODE),
    .CODE_ERR (CODE_ERR),
    .FRAME_ERR(FRAME_ERR),
    .BUSY     (BUSY),
    .HEX0     (HEX0)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic hold(input logic v, input int n);
    RX_IN = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expectEvent(input logic fe, input logic ce, input logic [7:0] d,
                             input logic [3:0] c, input logic [6:0] h);
    exp_t e;
    e.frame_err = fe;
    e.code_err  = ce;
    e.data      = d;
    e.code      = c;
    e.hex       = h;
    exp_q.push_back(e);
  endtask

  // Sends a frame MSB-first then two gap bits; glitch_bit selects a bit to dip low for one cycle at mid.
  task automatic applyStimulus(input logic [7:0] frame, input logic [1:0] gap, input int glitch_bit);
    for (int i = 7; i >= 0; i--) begin
      if ((7 - i) == glitch_bit) begin
        hold(1'b1, 9);
        hold(1'b0, 1);
        hold(1'b1, CPB - 10);
      end else begin
        hold(frame[i], CPB);
      end
    end
    for (int g = 1; g >= 0; g--) hold(gap[g], CPB);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (VALID || FRAME_ERR || CODE_ERR)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fail_count++;
        $display("[TB] FAIL unexpected_pulse: got valid=%0b frame_err=%0b code_err=%0b, expected no pulse",
                 VALID, FRAME_ERR, CODE_ERR);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pulses", 32'({VALID, FRAME_ERR, CODE_ERR}),
                    32'({~e.frame_err, e.frame_err, e.code_err}));
        checkOutput("payload", 32'({DATA, CODE, HEX0}), 32'({e.data, e.code, e.hex}));
      end
    end
  end

  initial begin
    RST   = 1'b1;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_outputs", 32'({DATA, CODE, HEX0, VALID, CODE_ERR, FRAME_ERR, BUSY}),
                32'({8'h00, 4'd0, 7'b0111111, 4'b0000}));
    RST = 1'b0;
    hold(1'b0, 2 * CPB);

    // Four legal codes sent back-to-back with exactly GB idle bits between them
    expectEvent(1'b0, 1'b0, 8'h80, 4'd0, 7'b1000000);
    applyStimulus(8'h80, 2'b00, -1);
    expectEvent(1'b0, 1'b0, 8'hA0, 4'd1, 7'b1111001);
    applyStimulus(8'hA0, 2'b00, -1);
    expectEvent(1'b0, 1'b0, 8'hA8, 4'd2, 7'b0100100);
    applyStimulus(8'hA8, 2'b00, -1);
    expectEvent(1'b0, 1'b0, 8'hAA, 4'd3, 7'b0110000);
    applyStimulus(8'hAA, 2'b00, -1);

    // Short high pulse: start is rejected with no pulse
    hold(1'b1, 4);
    hold(1'b0, 2);
    checkOutput("busy_during_false_start", 32'(BUSY), 32'd1);
    hold(1'b0, 30);
    checkOutput("busy_after_false_start", 32'(BUSY), 32'd0);
    checkOutput("hex_after_false_start", 32'(HEX0), 32'(7'b0110000));

    // Well-framed but illegal pattern
    expectEvent(1'b0, 1'b1, 8'hC0, 4'd3, 7'b0110000);
    applyStimulus(8'hC0, 2'b00, -1);

    // Gap bit high: framing error, then recover and decode
    expectEvent(1'b1, 1'b0, 8'hC0, 4'd3, 7'b0110000);
    applyStimulus(8'hA0, 2'b10, -1);
    checkOutput("busy_in_recover", 32'(BUSY), 32'd1);
    hold(1'b0, 2 * CPB);
    checkOutput("busy_after_recover", 32'(BUSY), 32'd0);
    expectEvent(1'b0, 1'b0, 8'h80, 4'd0, 7'b1000000);
    applyStimulus(8'h80, 2'b00, -1);

    // Reset in the middle of bit 4 of 10101010
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, 8);
    RST = 1'b1;
    #1;
    checkOutput("reset_mid_frame", 32'({DATA, CODE, HEX0, VALID, BUSY}),
                32'({8'h00, 4'd0, 7'b0111111, 2'b00}));
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    hold(1'b0, 2 * CPB);
    expectEvent(1'b0, 1'b0, 8'hA0, 4'd1, 7'b1111001);
    applyStimulus(8'hA0, 2'b00, -1);

    // One-cycle low glitch at mid of a '1' bit is out-voted
    expectEvent(1'b0, 1'b0, 8'hAA, 4'd3, 7'b0110000);
    applyStimulus(8'hAA, 2'b00, 2);

    hold(1'b0, 2 * CPB);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge CLK);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
